// File: rtl/qam16_symbol_sequencer.sv
// -----------------------------------------------------------------------------
// qam16_symbol_sequencer
//
// Accepts 4-bit QAM-16 symbols over a valid/ready handshake, maps each one to
// signed I/Q amplitude words, and holds each symbol for one full carrier period
// of 2**width_sel samples.  While a symbol is held it drives the phase index
// `sel` and the `start` qualifier for the downstream sine/cosine carrier
// multipliers.  A one-entry holding buffer lets consecutive symbols run
// back-to-back with no gap in `start`.
//
// Level map selection:
//   QAM_GRAY_MAP_EN defined     : Gray map    00->-3, 01->-1, 11->+1, 10->+3
//   QAM_GRAY_MAP_EN not defined : binary map  00->-3, 01->-1, 10->+1, 11->+3
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sym_in     in   symbol; [3:2] selects I level, [1:0] selects Q level
//   sym_valid  in   sym_in valid
//   sym_ready  out  holding buffer empty (driven straight from a flop)
//   i_data     out  signed I amplitude of the current symbol
//   q_data     out  signed Q amplitude of the current symbol
//   sel        out  carrier phase index of the current sample
//   start      out  i_data/q_data/sel are valid carrier inputs
//   sym_strobe out  one-cycle pulse on the first sample of each symbol
//   underrun   out  one-cycle pulse when a period ends with nothing buffered
// -----------------------------------------------------------------------------
module qam16_symbol_sequencer #(
  parameter int width_sym = 16,
  parameter int width_sel = 4,
  parameter int AMP_UNIT  = 2048
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  sym_in,
  input  logic                        sym_valid,
  output logic                        sym_ready,
  output logic signed [width_sym-1:0] i_data,
  output logic signed [width_sym-1:0] q_data,
  output logic [width_sel-1:0]        sel,
  output logic                        start,
  output logic                        sym_strobe,
  output logic                        underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [width_sel-1:0] SEL_MAX = '1;

  state_t                      state_q, state_d;
  logic                        buf_full_q, buf_full_d;
  logic [3:0]                  buf_sym_q, buf_sym_d;
  logic signed [width_sym-1:0] i_q, i_d;
  logic signed [width_sym-1:0] q_q, q_d;
  logic [width_sel-1:0]        sel_q, sel_d;
  logic                        start_q, start_d;
  logic                        strobe_q, strobe_d;
  logic                        underrun_q, underrun_d;
  logic                        accept;
  logic                        load;

  // Two-bit level selector to signed amplitude word.
  function automatic logic signed [width_sym-1:0] amp(input logic [1:0] bits);
    int lvl;
`ifdef QAM_GRAY_MAP_EN
    case (bits)
      2'b00:   lvl = -3;
      2'b01:   lvl = -1;
      2'b11:   lvl = 1;
      default: lvl = 3;
    endcase
`else
    case (bits)
      2'b00:   lvl = -3;
      2'b01:   lvl = -1;
      2'b10:   lvl = 1;
      default: lvl = 3;
    endcase
`endif
    return width_sym'(lvl * AMP_UNIT);
  endfunction

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_sym_d  = buf_sym_q;
    i_d        = i_q;
    q_d        = q_q;
    sel_d      = sel_q;
    start_d    = start_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    // Ready is the registered "buffer empty" flag, so an accept can only
    // land in an empty buffer.
    accept = sym_valid && !buf_full_q;

    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (buf_full_q) load = 1'b1;
      end
      default: begin
        if (sel_q != SEL_MAX) begin
          sel_d = sel_q + 1'b1;
        end else if (buf_full_q) begin
          load = 1'b1;
        end else begin
          state_d    = IDLE;
          start_d    = 1'b0;
          sel_d      = '0;
          i_d        = '0;
          q_d        = '0;
          underrun_d = 1'b1;
        end
      end
    endcase

    if (load) begin
      state_d    = RUN;
      i_d        = amp(buf_sym_q[3:2]);
      q_d        = amp(buf_sym_q[1:0]);
      sel_d      = '0;
      start_d    = 1'b1;
      strobe_d   = 1'b1;
      buf_full_d = 1'b0;
    end

    // A new symbol always goes through the buffer, even if it was just drained.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_sym_d  = sym_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
      sel_q      <= '0;
      start_q    <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      i_q        <= i_d;
      q_q        <= q_d;
      sel_q      <= sel_d;
      start_q    <= start_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Buffer payload is qualified by buf_full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_sym_q <= buf_sym_d;
  end

  assign sym_ready  = !buf_full_q;
  assign i_data     = i_q;
  assign q_data     = q_q;
  assign sel        = sel_q;
  assign start      = start_q;
  assign sym_strobe = strobe_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_qam16_symbol_sequencer.sv
module tb_qam16_symbol_sequencer;

  localparam int SYM_LEN = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         sym_in;
  logic               sym_valid;
  logic               sym_ready;
  logic signed [15:0] i_data;
  logic signed [15:0] q_data;
  logic [3:0]         sel;
  logic               start;
  logic               sym_strobe;
  logic               underrun;

  qam16_symbol_sequencer #(
    .width_sym(16),
    .width_sel(4),
    .AMP_UNIT (2048)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .i_data    (i_data),
    .q_data    (q_data),
    .sel       (sel),
    .start     (start),
    .sym_strobe(sym_strobe),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_err  = 0;
  int n_acc  = 0;
  int n_strb = 0;
  int n_disc = 0;

  // Symbol-schedule model: symbols waiting to play, the one playing now and
  // how far into its period it is.
  int         pend[$];
  logic [3:0] cur_sym;
  bit         active;
  int         pos;
  bit         strb_exp;
  bit         und_exp;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Amplitude from the level rule: levels are -3,-1,+1,+3 in order of index.
  function automatic int level(input logic [1:0] b);
    int idx;
`ifdef QAM_GRAY_MAP_EN
    idx = {b[1], b[1] ^ b[0]};
`else
    idx = b;
`endif
    return (2 * idx - 3) * 2048;
  endfunction

  task automatic model_reset();
    pend.delete();
    active   = 0;
    pos      = 0;
    strb_exp = 0;
    und_exp  = 0;
    cur_sym  = 4'h0;
  endtask

  task automatic model_edge(input bit acc, input logic [3:0] s);
    strb_exp = 0;
    und_exp  = 0;
    if (active) begin
      if (pos < SYM_LEN - 1) pos++;
      else if (pend.size() > 0) begin
        cur_sym  = 4'(pend.pop_front());
        pos      = 0;
        strb_exp = 1;
      end else begin
        active  = 0;
        pos     = 0;
        und_exp = 1;
      end
    end else if (pend.size() > 0) begin
      cur_sym  = 4'(pend.pop_front());
      active   = 1;
      pos      = 0;
      strb_exp = 1;
    end
    if (acc) begin
      pend.push_back(int'(s));
      n_acc++;
    end
  endtask

  task automatic check_outputs();
    chk("start", int'(start), int'(active));
    chk("sel", int'(sel), active ? pos : 0);
    chk("i_data", int'(i_data), active ? level(cur_sym[3:2]) : 0);
    chk("q_data", int'(q_data), active ? level(cur_sym[1:0]) : 0);
    chk("sym_strobe", int'(sym_strobe), int'(strb_exp));
    chk("underrun", int'(underrun), int'(und_exp));
    chk("sym_ready", int'(sym_ready), (pend.size() == 0) ? 1 : 0);
    if (sym_strobe) n_strb++;
  endtask

  // One clock: drive inputs, let the edge happen, sample on the falling edge.
  task automatic step(input bit v, input logic [3:0] s, output bit acc);
    sym_valid = v;
    sym_in    = s;
    acc       = v && (pend.size() == 0);
    @(posedge clk);
    model_edge(acc, s);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit         acc;
    int         idx;
    int         pct;
    logic [3:0] b2b [3];
    int         exp_i;

    b2b[0] = 4'b0000;
    b2b[1] = 4'b1111;
    b2b[2] = 4'b0110;
`ifdef QAM_GRAY_MAP_EN
    exp_i = 6144;
`else
    exp_i = 2048;
`endif

    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Idle after reset: nothing emitted, no underrun.
    for (int i = 0; i < 6; i++) step(0, 4'h0, acc);

    // Single symbol 4'b1001 through to its underrun.
    step(1, 4'b1001, acc);
    chk("single_accept", int'(acc), 1);
    sym_valid = 1'b0;
    @(posedge clk);
    model_edge(0, 4'h0);
    @(negedge clk);
    check_outputs();
    chk("single_i", int'(i_data), exp_i);
    chk("single_q", int'(q_data), -2048);
    chk("single_strobe", int'(sym_strobe), 1);
    for (int i = 0; i < SYM_LEN + 3; i++) step(0, 4'h0, acc);

    // Back-to-back stream with valid held high until all three are taken.
    idx = 0;
    for (int i = 0; i < 80; i++) begin
      if (idx < 3) begin
        step(1, b2b[idx], acc);
        if (acc) idx++;
      end else begin
        step(0, 4'h0, acc);
      end
    end
    chk("b2b_all_taken", idx, 3);

    // Randomized traffic with varying offered load.
    pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) pct = $urandom_range(0, 100);
      step(($urandom_range(0, 99) < pct), 4'($urandom), acc);
    end
    for (int i = 0; i < 2 * SYM_LEN + 4; i++) step(0, 4'h0, acc);

    // Reset in the middle of a symbol with a second symbol buffered.
    step(1, 4'b1100, acc);
    step(0, 4'h0, acc);
    step(1, 4'b0011, acc);
    chk("midrst_buffered", int'(pend.size()), 1);
    for (int i = 0; i < 20 && !(active && pos == 7); i++) step(0, 4'h0, acc);
    chk("midrst_at_sel7", int'(sel), 7);
    rst_n = 1'b0;
    #1;
    n_disc += pend.size();
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < SYM_LEN + 4; i++) step(0, 4'h0, acc);

    chk("strobe_count", n_strb, n_acc - n_disc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
